// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control unit.
//   state_t  : FSM states of mc_controller
//   iclass_t : instruction class produced by inst_decode
//   ALU_*    : aluop encodings driven to the datapath
//   OP_*     : RV32 major opcodes recognised by the decoder
//   WB_*     : write-back mux select codes
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_MULDIV = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_LOAD   = 3'd1,
    CL_STORE  = 3'd2,
    CL_BRANCH = 3'd3,
    CL_JUMP   = 3'd4,
    CL_CSR    = 3'd5,
    CL_MULDIV = 3'd6
  } iclass_t;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_CSR = 2'b11;

  // Integer ALU op for a func3; alt selects SUB/SRA (func7 = 0100000).
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_decode.sv
// Combinational instruction decoder.
// Maps the IR fields to an instruction class, ALU operation, operand-B
// select and an illegal flag.
//   i_opcode, i_func3, i_func7 : IR fields
//   o_class   : instruction class (ctrl_pkg::iclass_t)
//   o_aluop   : ALU operation code
//   o_sel_b   : 1 = immediate operand
//   o_illegal : instruction is not decodable with the current parameters
module inst_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_EN = 1,
  parameter int unsigned CSR_EN    = 1
) (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_func3,
  input  logic [6:0] i_func7,
  output iclass_t    o_class,
  output logic [4:0] o_aluop,
  output logic       o_sel_b,
  output logic       o_illegal
);

  always_comb begin
    o_class   = CL_ALU;
    o_aluop   = ALU_ADD;
    o_sel_b   = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R: begin
        if (i_func7 == F7_BASE) begin
          o_aluop = alu_from_f3(i_func3, 1'b0);
        end else if (i_func7 == F7_ALT && (i_func3 == 3'b000 || i_func3 == 3'b101)) begin
          o_aluop = alu_from_f3(i_func3, 1'b1);
        end else if (i_func7 == F7_MULDIV && MULDIV_EN != 0) begin
          o_class = CL_MULDIV;
          o_aluop = {2'b10, i_func3};
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        o_sel_b = 1'b1;
        case (i_func3)
          // Shift-immediates carry func7 in imm[11:5]; everything else is plain immediate.
          3'b001: begin
            if (i_func7 == F7_BASE) o_aluop = ALU_SLL;
            else                    o_illegal = 1'b1;
          end
          3'b101: begin
            if (i_func7 == F7_BASE)     o_aluop = ALU_SRL;
            else if (i_func7 == F7_ALT) o_aluop = ALU_SRA;
            else                        o_illegal = 1'b1;
          end
          default: o_aluop = alu_from_f3(i_func3, 1'b0);
        endcase
      end
      OP_LOAD: begin
        o_class = CL_LOAD;
        o_sel_b = 1'b1;
      end
      OP_STORE: begin
        o_class = CL_STORE;
        o_sel_b = 1'b1;
      end
      OP_BRANCH: begin
        o_class = CL_BRANCH;
        o_aluop = ALU_SUB;
      end
      OP_JAL, OP_JALR: begin
        o_class = CL_JUMP;
        o_sel_b = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        o_sel_b = 1'b1;
      end
      OP_SYSTEM: begin
        if (i_func3 != 3'b000 && CSR_EN != 0) o_class = CL_CSR;
        else                                  o_illegal = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase

    // Illegal instructions present a neutral op so nothing downstream sees stale codes.
    if (o_illegal) begin
      o_class = CL_ALU;
      o_aluop = ALU_ADD;
      o_sel_b = 1'b0;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I(+M, +Zicsr) control FSM.
// Sequences FETCH -> DECODE -> EXEC/MULDIV -> MEM -> WB and drives the
// datapath strobes; illegal instructions park the FSM in TRAP until reset.
//   clk, rst_n          : clock, asynchronous active-low reset
//   opcode/func3/func7  : IR fields (stable after ir_en)
//   mem_ready, br_taken : memory acknowledge, branch comparator result
//   aluop, sel_B        : ALU op and operand-B select (DECODE..WB)
//   rf_en, ir_en, pc_en, pc_sel, mem_req, mem_we, wb_sel, csr_we : strobes
//   illegal             : high while in TRAP
module mc_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_EN  = 1,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CSR_EN     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic [4:0] aluop,
  output logic       sel_B,
  output logic       rf_en,
  output logic       ir_en,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] wb_sel,
  output logic       csr_we,
  output logic       illegal
);

  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  // Low from reset until the first clock edge: keeps FETCH quiet until then.
  logic       r_run;

  iclass_t    w_class;
  logic [4:0] w_aluop;
  logic       w_sel_b;
  logic       w_illegal;

  inst_decode #(
    .MULDIV_EN (MULDIV_EN),
    .CSR_EN    (CSR_EN)
  ) u_dec (
    .i_opcode  (opcode),
    .i_func3   (func3),
    .i_func7   (func7),
    .o_class   (w_class),
    .o_aluop   (w_aluop),
    .o_sel_b   (w_sel_b),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // Loaded on DECODE->MULDIV; WB is taken in the cycle it reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (r_state == ST_DECODE && w_next == ST_MULDIV) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == ST_MULDIV && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (r_run && mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_illegal)                  w_next = ST_TRAP;
        else if (w_class == CL_MULDIV)  w_next = ST_MULDIV;
        else                            w_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (w_class)
          CL_LOAD, CL_STORE: w_next = ST_MEM;
          CL_BRANCH:         w_next = ST_FETCH;
          default:           w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) w_next = (w_class == CL_STORE) ? ST_FETCH : ST_WB;
      end
      ST_MULDIV: if (r_cnt == 4'd0) w_next = ST_WB;
      ST_WB:     w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    aluop   = ALU_ADD;
    sel_B   = 1'b0;
    rf_en   = 1'b0;
    ir_en   = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    wb_sel  = WB_ALU;
    csr_we  = 1'b0;
    illegal = 1'b0;

    if (r_state == ST_DECODE || r_state == ST_EXEC || r_state == ST_MEM ||
        r_state == ST_MULDIV || r_state == ST_WB) begin
      aluop = w_aluop;
      sel_B = w_sel_b;
    end

    case (r_state)
      ST_FETCH: begin
        mem_req = r_run;
        ir_en   = r_run & mem_ready;
      end
      ST_EXEC: begin
        if (w_class == CL_BRANCH) begin
          pc_en  = 1'b1;
          pc_sel = br_taken;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_class == CL_STORE);
        pc_en   = (w_class == CL_STORE) & mem_ready;
      end
      ST_WB: begin
        rf_en = 1'b1;
        pc_en = 1'b1;
        case (w_class)
          CL_LOAD: wb_sel = WB_MEM;
          CL_JUMP: begin
            wb_sel = WB_PC4;
            pc_sel = 1'b1;
          end
          CL_CSR: begin
            wb_sel = WB_CSR;
            csr_we = 1'b1;
          end
          default: wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
